perf_counter_unit: RTL and testbench
====================================

# perf_counter_unit

Hardware performance-counter block instantiated inside `cpu`. It counts elapsed cycles, retired instructions (writeback register-write strobes) and pipeline stall cycles under software-style start/stop/clear control. Values are exposed through a registered read port, so firmware and benches read the same figures as the simulation-only cycle/instruction tally. It is the on-chip producer side of the performance data the top-level bench reports.

## Interface

Parameters:
- `CNT_W`, 32, width of each counter and of `rd_data`

Ports:
- `clk`, input, 1, single clock; all state updates on rising edge
- `rst`, input, 1, asynchronous, active-low reset
- `retire_i`, input, 1, one-cycle strobe per retired instruction; driven from `WB_RegWrite_O`
- `stall_i`, input, 1, high in each cycle the pipeline front end is stalled
- `ctl_we`, input, 1, control write strobe
- `ctl_wdata`, input, 2, bit0 = start (1) / stop (0); bit1 = clear
- `rd_en`, input, 1, read request
- `rd_addr`, input, 2, 0 = cycles, 1 = retired (snapshot), 2 = stalls (snapshot), 3 = status
- `rd_data`, output, CNT_W, read result
- `rd_valid`, output, 1, `rd_data` is valid this cycle
- `running`, output, 1, high while in RUN
- `ovf`, output, 3, sticky wrap flags: bit0 cycles, bit1 retired, bit2 stalls

## Operation

- **FSM states:** IDLE (reset state), RUN, HALT.
- **With `ctl_we`=1:**
  - IDLE or HALT with start=1 -> RUN.
  - RUN with start=0 -> HALT.
  - IDLE with start=0 stays in IDLE.
  - No transitions without `ctl_we`.
- **Clear:** `ctl_we` with bit1=1 zeroes all counters, snapshots and `ovf` at that edge, in any state.
  - Clear beats any increment in the same cycle.
  - The start/stop bit in the same write is still applied, so clear+start gives RUN from zero.
- **Counting:** only at edges where the current state is RUN.
  - Cycle counter increments by 1 every such edge.
  - Retired counter increments when `retire_i`=1.
  - Stall counter increments when `stall_i`=1.
  - A control write that leaves RUN still counts at that same edge, because the state before the edge was RUN.
- **Wrap:** a counter at 2^CNT_W-1 wraps to 0 and sets its `ovf` bit. `ovf` bits stay set until a clear or reset.
- **Snapshot coherence:**
  - A read of addr 0 returns the live cycle count.
  - The same read copies the live retired and stall values into shadow registers at that edge, including any increment occurring at that edge.
  - Reads of addr 1 and 2 return the shadows.
- **Status word (addr 3):** `{zero-extended, ovf[2:0], state==RUN}` in the low 4 bits.
- **Read timing:** `rd_en` at edge N gives `rd_data`/`rd_valid` during cycle N+1. `rd_valid` is a one-cycle pulse. Back-to-back reads are allowed every cycle.
- **Read of addr 0 during counting:** returns the value before the increment at edge N.
- **Read and control write in the same cycle:** the read sees pre-write values.
- **`rd_data`:** holds its last value when `rd_valid`=0.

## Timing

- Reset values: state IDLE, all counters/shadows 0, `rd_data`=0, `rd_valid`=0, `running`=0, `ovf`=0.
- Reset mid-operation clears everything immediately (asynchronously). First counting edge is one edge after a start write is sampled following reset release.
- `running` is registered state and rises in the cycle after the start write edge.
- Read latency is 1 cycle. Control latency is 1 edge.

## Configuration

- `PERF_STALL_CNT_EN` defined: stall counter, its shadow and `ovf[2]` are implemented as described.
- Not defined:
  - `stall_i` is ignored.
  - addr 2 reads 0.
  - `ovf[2]` is tied to 0.
  - No stall-counter storage is synthesized.

## Test plan

- Reset (`rst`=0 for 2 cycles), then start, run 10 edges with `retire_i`=1 on 4 of them, stop -> addr 0 reads 10, addr 1 reads 4 after an addr 0 read, `running`=0.
- CNT_W=4, start, 16 edges -> cycle counter reads 0, status reads 0x3 (`ovf[0]`=1, running). Then clear+start -> status 0x1, cycle counter 0.
- `retire_i`=1 continuously and addr 0 read at cycle 7 -> addr 1 returns the snapshot taken at that edge (equal to addr 0 value + 1) even after 5 more counting cycles.
- Clear write in the same cycle as `retire_i`=1 in RUN -> retired counter reads 0.
- Assert `rst` low mid-RUN with counters at 20 -> outputs immediately 0, state IDLE, no counting until a new start.
- With `PERF_STALL_CNT_EN`: `stall_i` high 3 of 8 RUN cycles -> addr 2 reads 3. Without the macro -> addr 2 reads 0.

Source files
------------

// File: rtl/perf_counter_unit_if.sv
// Bundle of the counter unit's event inputs, control/read request port and read/status outputs.
// master drives events, control and read requests; slave is the counter unit itself.
interface perf_counter_unit_if #(parameter int CNT_W = 32);
  logic             retire_i;
  logic             stall_i;
  logic             ctl_we;
  logic [1:0]       ctl_wdata;
  logic             rd_en;
  logic [1:0]       rd_addr;
  logic [CNT_W-1:0] rd_data;
  logic             rd_valid;
  logic             running;
  logic [2:0]       ovf;

  modport master (
    output retire_i, stall_i, ctl_we, ctl_wdata, rd_en, rd_addr,
    input  rd_data, rd_valid, running, ovf
  );

  modport slave (
    input  retire_i, stall_i, ctl_we, ctl_wdata, rd_en, rd_addr,
    output rd_data, rd_valid, running, ovf
  );
endinterface

// File: rtl/perf_counter_unit.sv
// Cycle/retired/stall counters with start/stop/clear and a snapshot read port; stall counter only with PERF_STALL_CNT_EN.
// Control latency 1 edge, read latency 1 cycle; no backpressure, a read is accepted every cycle.
module perf_counter_unit #(
  parameter int CNT_W = 32
) (
  input logic                clk,
  input logic                rst,
  perf_counter_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic [CNT_W-1:0] ret_shd_q, ret_shd_d;
  logic [2:0]       ovf_q, ovf_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0] stl_rd;
  logic [CNT_W-1:0] status;
  logic             stl_wrap;
  logic             is_run, clr, snap;

  assign is_run = (state_q == RUN);
  assign clr    = bus.ctl_we & bus.ctl_wdata[1];
  assign snap   = bus.rd_en & (bus.rd_addr == 2'd0);

`ifdef PERF_STALL_CNT_EN
  logic [CNT_W-1:0] stl_q, stl_d, stl_shd_q, stl_shd_d;

  always_comb begin
    stl_d     = stl_q;
    stl_shd_d = stl_shd_q;
    stl_wrap  = 1'b0;
    if (is_run && bus.stall_i) begin
      stl_d    = stl_q + CNT_W'(1);
      stl_wrap = &stl_q;
    end
    if (snap) stl_shd_d = stl_d;
    if (clr) begin
      stl_d     = '0;
      stl_shd_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stl_q     <= '0;
      stl_shd_q <= '0;
    end else begin
      stl_q     <= stl_d;
      stl_shd_q <= stl_shd_d;
    end
  end

  assign stl_rd = stl_shd_q;
`else
  logic unused_stall;
  assign unused_stall = bus.stall_i;
  assign stl_wrap     = 1'b0;
  assign stl_rd       = '0;
`endif

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    ret_d      = ret_q;
    ret_shd_d  = ret_shd_q;
    ovf_d      = ovf_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = bus.rd_en;
    status     = '0;
    status[3:0] = {ovf_q, is_run};

    // Counting keys off the state before the edge, so a stop write still counts.
    if (is_run) begin
      cyc_d = cyc_q + CNT_W'(1);
      if (&cyc_q) ovf_d[0] = 1'b1;
      if (bus.retire_i) begin
        ret_d = ret_q + CNT_W'(1);
        if (&ret_q) ovf_d[1] = 1'b1;
      end
    end
    if (stl_wrap) ovf_d[2] = 1'b1;

    // Shadow captures the post-increment value of this same edge.
    if (snap) ret_shd_d = ret_d;

    if (clr) begin
      cyc_d     = '0;
      ret_d     = '0;
      ret_shd_d = '0;
      ovf_d     = '0;
    end

    if (bus.ctl_we) begin
      unique case (state_q)
        IDLE:    if (bus.ctl_wdata[0]) state_d = RUN;
        HALT:    if (bus.ctl_wdata[0]) state_d = RUN;
        RUN:     if (!bus.ctl_wdata[0]) state_d = HALT;
        default: state_d = IDLE;
      endcase
    end

    // Read mux uses pre-edge values so a concurrent control write is not visible.
    if (bus.rd_en) begin
      unique case (bus.rd_addr)
        2'd0:    rd_data_d = cyc_q;
        2'd1:    rd_data_d = ret_shd_q;
        2'd2:    rd_data_d = stl_rd;
        default: rd_data_d = status;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cyc_q      <= '0;
      ret_q      <= '0;
      ret_shd_q  <= '0;
      ovf_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      ret_q      <= ret_d;
      ret_shd_q  <= ret_shd_d;
      ovf_q      <= ovf_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.running  = is_run;
  assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_perf_counter_unit.sv
// Directed bench for perf_counter_unit: a 32-bit instance for the main flows and a 4-bit instance for wrap.
module tb_perf_counter_unit;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  perf_counter_unit_if #(.CNT_W(32)) if32 ();
  perf_counter_unit_if #(.CNT_W(4))  if4 ();

  perf_counter_unit #(.CNT_W(32)) u32 (.clk(clk), .rst(rst_n), .bus(if32));
  perf_counter_unit #(.CNT_W(4))  u4  (.clk(clk), .rst(rst_n), .bus(if4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic ctl(input logic [1:0] w);
    if32.ctl_we    = 1'b1;
    if32.ctl_wdata = w;
    tick();
    if32.ctl_we    = 1'b0;
    if32.ctl_wdata = 2'b00;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
    if32.rd_en   = 1'b1;
    if32.rd_addr = a;
    tick();
    if32.rd_en   = 1'b0;
    chk({nm, "_vld"}, 32'(if32.rd_valid), 32'd1);
    chk(nm, if32.rd_data, exp);
  endtask

  task automatic rd4(input logic [1:0] a, input logic [31:0] exp, input string nm);
    if4.rd_en   = 1'b1;
    if4.rd_addr = a;
    tick();
    if4.rd_en   = 1'b0;
    chk(nm, 32'(if4.rd_data), exp);
  endtask

  initial begin
    logic [9:0]  ret_pat;
    logic [9:0]  stl_pat;
    logic [31:0] exp_stl;

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    if32.retire_i = 1'b0; if32.stall_i = 1'b0; if32.ctl_we = 1'b0;
    if32.ctl_wdata = 2'b00; if32.rd_en = 1'b0; if32.rd_addr = 2'd0;
    if4.retire_i = 1'b0; if4.stall_i = 1'b0; if4.ctl_we = 1'b0;
    if4.ctl_wdata = 2'b00; if4.rd_en = 1'b0; if4.rd_addr = 2'd0;

`ifdef PERF_STALL_CNT_EN
    exp_stl = 32'd3;
`else
    exp_stl = 32'd0;
`endif
    // Expected reads after 10 RUN edges: 4 retires, 3 stalls, stopped.
    tbl[0] = '{2'd0, 32'd10,  "cyc"};
    tbl[1] = '{2'd1, 32'd4,   "ret_snap"};
    tbl[2] = '{2'd2, exp_stl, "stl_snap"};
    tbl[3] = '{2'd3, 32'd0,   "status"};
    tbl[4] = '{2'd0, 32'd10,  "cyc_again"};
    ret_pat = 10'b10_0010_1010;
    stl_pat = 10'b10_0001_0001;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_data",  if32.rd_data, 32'd0);
    chk("rst_rd_valid", 32'(if32.rd_valid), 32'd0);
    chk("rst_running",  32'(if32.running), 32'd0);
    chk("rst_ovf",      32'(if32.ovf), 32'd0);
    rst_n = 1'b1;

    // Basic run: start, 10 counting edges with the stop write on the last.
    ctl(2'b01);
    chk("run_after_start", 32'(if32.running), 32'd1);
    for (int i = 0; i < 10; i++) begin
      if32.retire_i  = ret_pat[i];
      if32.stall_i   = stl_pat[i];
      if32.ctl_we    = (i == 9);
      if32.ctl_wdata = 2'b00;
      tick();
    end
    if32.retire_i = 1'b0;
    if32.stall_i  = 1'b0;
    if32.ctl_we   = 1'b0;
    chk("run_after_stop", 32'(if32.running), 32'd0);
    for (int i = 0; i < 5; i++) rd(tbl[i].addr, tbl[i].exp, tbl[i].name);
    tick();
    chk("hold_vld",  32'(if32.rd_valid), 32'd0);
    chk("hold_data", if32.rd_data, 32'd10);

    // Snapshot coherence with continuous retires.
    if32.retire_i = 1'b1;
    ctl(2'b11);
    repeat (6) tick();
    rd(2'd0, 32'd6, "snap_cyc");
    repeat (5) tick();
    rd(2'd1, 32'd7, "snap_ret");
    if32.retire_i = 1'b0;
    ctl(2'b00);

    // Clear in the same edge as a retire while running.
    ctl(2'b01);
    if32.retire_i = 1'b1;
    tick();
    ctl(2'b11);
    if32.retire_i = 1'b0;
    ctl(2'b00);
    rd(2'd0, 32'd1, "clr_cyc");
    rd(2'd1, 32'd0, "clr_ret");

    // Asynchronous reset mid-RUN.
    ctl(2'b11);
    repeat (20) tick();
    rd(2'd0, 32'd20, "pre_rst_cyc");
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_running", 32'(if32.running), 32'd0);
    chk("arst_rd_data", if32.rd_data, 32'd0);
    chk("arst_ovf",     32'(if32.ovf), 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_running", 32'(if32.running), 32'd0);
    rd(2'd0, 32'd0, "idle_cyc");
    ctl(2'b01);
    rd(2'd0, 32'd0, "first_edge_cyc");
    rd(2'd0, 32'd1, "second_edge_cyc");

    // 4-bit instance: wrap after 16 edges, then clear+start.
    if4.ctl_we    = 1'b1;
    if4.ctl_wdata = 2'b01;
    tick();
    if4.ctl_we    = 1'b0;
    repeat (16) tick();
    chk("w4_ovf", 32'(if4.ovf), 32'd1);
    rd4(2'd0, 32'd0, "w4_cyc");
    rd4(2'd3, 32'd3, "w4_status");
    if4.ctl_we    = 1'b1;
    if4.ctl_wdata = 2'b11;
    if4.rd_en     = 1'b1;
    if4.rd_addr   = 2'd3;
    tick();
    if4.ctl_we    = 1'b0;
    if4.rd_en     = 1'b0;
    chk("w4_prewrite_status", 32'(if4.rd_data), 32'd3);
    rd4(2'd0, 32'd0, "w4_clr_cyc");
    rd4(2'd3, 32'd1, "w4_clr_status");
    chk("w4_clr_ovf", 32'(if4.ovf), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
